// File: rtl/mc_ctrl.sv
// mc_ctrl: main control FSM of the multi-cycle MIPS core, plus retired-instruction counter.
// Build option MC_MEM_READY_EN adds the mem_ready handshake that stalls FETCH, MEMRD and MEMWR.
module mc_ctrl #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
`ifdef MC_MEM_READY_EN
   input  logic             mem_ready,
`endif
   output logic             PCWrite,
   output logic [1:0]       PCSrc,
   output logic             IRWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [2:0]       ALUOp,
   output logic [1:0]       EXTOp,
   output logic             RegWrite,
   output logic [1:0]       RegDst,
   output logic [1:0]       WDSel,
   output logic             MemWrite,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXE    = 3'd2,
      S_MEMRD  = 3'd3,
      S_MEMWB  = 3'd4,
      S_MEMWR  = 3'd5,
      S_ALUWB  = 3'd6
   } state_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_OR  = 3'b010;
   localparam logic [2:0] ALU_LUI = 3'b011;

   state_t state_q;
   state_t state_d;
   logic   mem_ok;

`ifdef MC_MEM_READY_EN
   assign mem_ok = mem_ready;
`else
   assign mem_ok = 1'b1;
`endif

   // Instruction decode
   logic is_r;
   logic is_addu;
   logic is_subu;
   logic is_jr;
   logic is_ori;
   logic is_lui;
   logic is_lw;
   logic is_sw;
   logic is_beq;
   logic is_j;
   logic is_jal;
   logic needs_exe;

   always_comb begin
      is_r      = (opcode == 6'b000000);
      is_addu   = is_r && (funct == 6'b100001);
      is_subu   = is_r && (funct == 6'b100011);
      is_jr     = is_r && (funct == 6'b001000);
      is_ori    = (opcode == 6'b001101);
      is_lui    = (opcode == 6'b001111);
      is_lw     = (opcode == 6'b100011);
      is_sw     = (opcode == 6'b101011);
      is_beq    = (opcode == 6'b000100);
      is_j      = (opcode == 6'b000010);
      is_jal    = (opcode == 6'b000011);
      needs_exe = is_addu | is_subu | is_ori | is_lui | is_lw | is_sw | is_beq;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   logic       pc_write;
   logic [1:0] pc_src;
   logic       ir_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_op;
   logic [1:0] ext_op;
   logic       reg_write;
   logic [1:0] reg_dst;
   logic [1:0] wd_sel;
   logic       mem_write;

   always_comb begin
      state_d   = state_q;
      pc_write  = 1'b0;
      pc_src    = 2'b00;
      ir_write  = 1'b0;
      alu_src_a = 1'b0;
      alu_src_b = 2'b00;
      alu_op    = ALU_ADD;
      ext_op    = 2'b00;
      reg_write = 1'b0;
      reg_dst   = 2'b00;
      wd_sel    = 2'b00;
      mem_write = 1'b0;

      case (state_q)
         S_FETCH: begin
            alu_src_b = 2'b01;
            if (mem_ok) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end

         S_DECODE: begin
            // Branch target is computed here unconditionally and latched into ALUOut.
            alu_src_b = 2'b11;
            ext_op    = 2'b01;
            if (is_j || is_jal) begin
               pc_write = 1'b1;
               pc_src   = 2'b10;
               state_d  = S_FETCH;
               if (is_jal) begin
                  reg_write = 1'b1;
                  reg_dst   = 2'b10;
                  wd_sel    = 2'b10;
               end
            end else if (is_jr) begin
               pc_write = 1'b1;
               pc_src   = 2'b11;
               state_d  = S_FETCH;
            end else if (needs_exe) begin
               state_d = S_EXE;
            end else begin
               state_d = S_FETCH;
            end
         end

         S_EXE: begin
            if (is_addu || is_subu) begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b00;
               alu_op    = is_subu ? ALU_SUB : ALU_ADD;
               state_d   = S_ALUWB;
            end else if (is_ori) begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               alu_op    = ALU_OR;
               state_d   = S_ALUWB;
            end else if (is_lui) begin
               alu_src_b = 2'b10;
               alu_op    = ALU_LUI;
               state_d   = S_ALUWB;
            end else if (is_lw || is_sw) begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               ext_op    = 2'b01;
               state_d   = is_lw ? S_MEMRD : S_MEMWR;
            end else if (is_beq) begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b00;
               alu_op    = ALU_SUB;
               pc_write  = zero;
               pc_src    = 2'b01;
               state_d   = S_FETCH;
            end else begin
               state_d = S_FETCH;
            end
         end

         S_MEMRD: begin
            if (mem_ok) begin
               state_d = S_MEMWB;
            end
         end

         S_MEMWB: begin
            reg_write = 1'b1;
            reg_dst   = 2'b00;
            wd_sel    = 2'b01;
            state_d   = S_FETCH;
         end

         S_MEMWR: begin
            mem_write = 1'b1;
            if (mem_ok) begin
               state_d = S_FETCH;
            end
         end

         S_ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = is_r ? 2'b01 : 2'b00;
            wd_sel    = 2'b00;
            state_d   = S_FETCH;
         end

         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // Reset parks the FSM in FETCH, whose enables must not leak out while reset is held.
   assign PCWrite  = pc_write  & ~reset;
   assign IRWrite  = ir_write  & ~reset;
   assign RegWrite = reg_write & ~reset;
   assign MemWrite = mem_write & ~reset;
   assign PCSrc    = pc_src;
   assign ALUSrcA  = alu_src_a;
   assign ALUSrcB  = alu_src_b;
   assign ALUOp    = alu_op;
   assign EXTOp    = ext_op;
   assign RegDst   = reg_dst;
   assign WDSel    = wd_sel;
   assign state    = state_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retired <= '0;
      end else if ((state_q != S_FETCH) && (state_d == S_FETCH)) begin
         retired <= retired + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized scoreboard bench for mc_ctrl: expected per-cycle control words are queued by the
// stimulus process from an instruction-level model and compared by an independent monitor.
module tb_mc_ctrl;

   localparam int CW = 3;

   logic          clk;
   logic          reset;
   logic [5:0]    opcode;
   logic [5:0]    funct;
   logic          zero;
   logic          mem_ready;
   logic          PCWrite;
   logic [1:0]    PCSrc;
   logic          IRWrite;
   logic          ALUSrcA;
   logic [1:0]    ALUSrcB;
   logic [2:0]    ALUOp;
   logic [1:0]    EXTOp;
   logic          RegWrite;
   logic [1:0]    RegDst;
   logic [1:0]    WDSel;
   logic          MemWrite;
   logic [2:0]    state;
   logic [CW-1:0] retired;

   mc_ctrl #(.CNT_W(CW)) dut (
      .clk      (clk),
      .reset    (reset),
      .opcode   (opcode),
      .funct    (funct),
      .zero     (zero),
`ifdef MC_MEM_READY_EN
      .mem_ready(mem_ready),
`endif
      .PCWrite  (PCWrite),
      .PCSrc    (PCSrc),
      .IRWrite  (IRWrite),
      .ALUSrcA  (ALUSrcA),
      .ALUSrcB  (ALUSrcB),
      .ALUOp    (ALUOp),
      .EXTOp    (EXTOp),
      .RegWrite (RegWrite),
      .RegDst   (RegDst),
      .WDSel    (WDSel),
      .MemWrite (MemWrite),
      .state    (state),
      .retired  (retired)
   );

   typedef struct packed {
      logic [2:0]    st;
      logic          pcw;
      logic [1:0]    pcsrc;
      logic          irw;
      logic          srca;
      logic [1:0]    srcb;
      logic [2:0]    aluop;
      logic [1:0]    ext;
      logic          regw;
      logic [1:0]    regdst;
      logic [1:0]    wdsel;
      logic          memw;
      logic [CW-1:0] ret;
   } rec_t;

   typedef enum int {K_NOP, K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL} kind_t;

   rec_t exp_q[$];
   rec_t plan_q[$];
   logic rdy_q[$];
   int   errors = 0;
   int   checks = 0;
   int   n_ret  = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1);
   end

   function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         6'b000000: begin
            if (fn == 6'b100001) return K_ADDU;
            if (fn == 6'b100011) return K_SUBU;
            if (fn == 6'b001000) return K_JR;
            return K_NOP;
         end
         6'b001101: return K_ORI;
         6'b001111: return K_LUI;
         6'b100011: return K_LW;
         6'b101011: return K_SW;
         6'b000100: return K_BEQ;
         6'b000010: return K_J;
         6'b000011: return K_JAL;
         default:   return K_NOP;
      endcase
   endfunction

   function automatic rec_t mk(input int st);
      rec_t r;
      r     = '0;
      r.st  = 3'(st);
      r.ret = CW'(n_ret % (2 ** CW));
      return r;
   endfunction

   task automatic add(input rec_t r, input logic rdy);
      plan_q.push_back(r);
      rdy_q.push_back(rdy);
   endtask

   // Builds the cycle-by-cycle control words one instruction is expected to produce.
   task automatic plan(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int sf, input int srd, input int swr);
      kind_t k;
      rec_t  r;
      k = classify(op, fn);
      for (int i = 0; i < sf; i++) begin
         r = mk(0); r.srcb = 2'b01; add(r, 1'b0);
      end
      r = mk(0); r.pcw = 1; r.irw = 1; r.srcb = 2'b01; add(r, 1'b1);
      r = mk(1); r.srcb = 2'b11; r.ext = 2'b01;
      if (k == K_J || k == K_JAL) begin r.pcw = 1; r.pcsrc = 2'b10; end
      if (k == K_JAL) begin r.regw = 1; r.regdst = 2'b10; r.wdsel = 2'b10; end
      if (k == K_JR) begin r.pcw = 1; r.pcsrc = 2'b11; end
      add(r, 1'($urandom));
      if (k == K_NOP || k == K_J || k == K_JAL || k == K_JR) begin
         n_ret++;
         return;
      end
      r = mk(2);
      case (k)
         K_ADDU:    begin r.srca = 1; r.aluop = 3'd0; end
         K_SUBU:    begin r.srca = 1; r.aluop = 3'd1; end
         K_ORI:     begin r.srca = 1; r.srcb = 2'b10; r.aluop = 3'd2; end
         K_LUI:     begin r.srcb = 2'b10; r.aluop = 3'd3; end
         K_LW, K_SW: begin r.srca = 1; r.srcb = 2'b10; r.ext = 2'b01; end
         default:   begin r.srca = 1; r.aluop = 3'd1; r.pcw = z; r.pcsrc = 2'b01; end
      endcase
      add(r, 1'($urandom));
      if (k == K_ADDU || k == K_SUBU || k == K_ORI || k == K_LUI) begin
         r = mk(6); r.regw = 1; r.regdst = (k == K_ADDU || k == K_SUBU) ? 2'b01 : 2'b00;
         add(r, 1'($urandom));
      end else if (k == K_LW) begin
         for (int i = 0; i < srd; i++) add(mk(3), 1'b0);
         add(mk(3), 1'b1);
         r = mk(4); r.regw = 1; r.wdsel = 2'b01; add(r, 1'($urandom));
      end else if (k == K_SW) begin
         for (int i = 0; i <= swr; i++) begin
            r = mk(5); r.memw = 1; add(r, (i == swr) ? 1'b1 : 1'b0);
         end
      end
      n_ret++;
   endtask

   // Entered one time unit after a rising edge with the DUT at the start of FETCH.
   task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input int sf, input int srd, input int swr);
      opcode = op; funct = fn; zero = z;
      plan(op, fn, z, sf, srd, swr);
      while (plan_q.size() > 0) begin
         mem_ready = rdy_q.pop_front();
         exp_q.push_back(plan_q.pop_front());
         @(posedge clk); #1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin : monitor
      rec_t e;
      rec_t a;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {state, PCWrite, PCSrc, IRWrite, ALUSrcA, ALUSrcB, ALUOp, EXTOp,
                 RegWrite, RegDst, WDSel, MemWrite, retired};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL cycle@%0t op=%b fn=%b: got %h expected %h (state got %0d expected %0d)",
                        $time, opcode, funct, a, e, a.st, e.st);
            end
         end
      end
   end

   function automatic int stall();
`ifdef MC_MEM_READY_EN
      return int'($urandom_range(0, 3));
`else
      return 0;
`endif
   endfunction

   logic [5:0] tops[12];
   logic [5:0] tfns[12];

   initial begin : stim
      int idx;
      int w;
      tops = '{6'b000000, 6'b000000, 6'b100011, 6'b001101, 6'b001111, 6'b000100,
               6'b000100, 6'b000011, 6'b000010, 6'b000000, 6'b101011, 6'b000000};
      tfns = '{6'b100001, 6'b100011, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
               6'b000000, 6'b000000, 6'b000000, 6'b001000, 6'b000000, 6'b000000};
      reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_retired", 32'(retired), 32'd0);
      chk("reset_writes", {28'd0, PCWrite, IRWrite, RegWrite, MemWrite}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Directed pass over every instruction class, then a randomized mix.
      for (int i = 0; i < 12; i++) begin
         run(tops[i], tfns[i], (i == 5) ? 1'b1 : 1'b0, stall(), stall(), stall());
      end
`ifdef MC_MEM_READY_EN
      run(6'b101011, 6'b000000, 1'b0, 0, 0, 3);
`endif
      for (int i = 0; i < 80; i++) begin
         idx = int'($urandom_range(0, 12));
         if (idx >= 12)
            run(6'($urandom), 6'($urandom), 1'($urandom), stall(), stall(), stall());
         else
            run(tops[idx], tfns[idx], 1'($urandom), stall(), stall(), stall());
      end

      // Reset asserted part-way through the EXE cycle of addu.
      opcode = 6'b000000; funct = 6'b100001; zero = 1'b0; mem_ready = 1'b1;
      plan(opcode, funct, zero, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(plan_q.pop_front());
         void'(rdy_q.pop_front());
         if (i < 2) begin
            @(posedge clk); #1;
         end
      end
      plan_q.delete(); rdy_q.delete();
      @(negedge clk); #1;
      reset = 1'b1;
      #1;
      chk("midexe_reset_state", 32'(state), 32'd0);
      chk("midexe_reset_retired", 32'(retired), 32'd0);
      chk("midexe_reset_writes", {28'd0, PCWrite, IRWrite, RegWrite, MemWrite}, 32'd0);
      @(posedge clk); #1;
      chk("reset_hold_state", 32'(state), 32'd0);
      chk("reset_hold_regwrite", 32'(RegWrite), 32'd0);
      reset = 1'b0;
      n_ret = 0;
      for (int i = 0; i < 12; i++) begin
         run(tops[i], tfns[i], 1'($urandom), stall(), stall(), stall());
      end

      w = 0;
      while (exp_q.size() > 0 && w < 20) begin
         @(posedge clk);
         w++;
      end
      if (exp_q.size() > 0) begin
         errors++;
         checks++;
         $display("FAIL drain: %0d expected cycles left unchecked, required 0", exp_q.size());
      end
      @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
